regfile_port_arbiter: RTL and testbench
=======================================

# regfile_port_arbiter

Clocked controller that shares the 8-entry register file between two requesters (A and B), each issuing a combined read-read-optional-write operation. It arbitrates round-robin, latches the winning request, and sequences the register file through a fixed read phase, write phase and response phase. It sits between the register file and its clients, and is the only block that drives the register file address, data and write-enable lines.

## Interface
- BITS_DATA, 32, register width
- BITS_ADDR, 3, register address width (2^BITS_ADDR entries)

- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid_a / req_valid_b  in  1  request pending from A / B
- req_ready_a / req_ready_b  out  1  request accepted this cycle (handshake = valid & ready)
- req_we_a / req_we_b  in  1  operation includes a write
- req_raddr1_a, req_raddr2_a / _b  in  BITS_ADDR  source register addresses
- req_waddr_a / req_waddr_b  in  BITS_ADDR  destination register address
- req_wdata_a / req_wdata_b  in  BITS_DATA  write data
- rsp_valid_a / rsp_valid_b  out  1  one-cycle response strobe to A / B
- rsp_rdata1, rsp_rdata2  out  BITS_DATA  read results, shared by both requesters; valid while rsp_valid_x is high
- rf_raddr1, rf_raddr2  out  BITS_ADDR  register file read addresses
- rf_rdata1, rf_rdata2  in  BITS_DATA  register file read data, combinational from rf_raddr
- rf_we  out  1  register file write enable; the register file writes on the rising clk edge
- rf_waddr  out  BITS_ADDR  register file write address
- rf_wdata  out  BITS_DATA  register file write data

## Operation
- FSM states: IDLE, READ, WRITE, RESP. After reset: IDLE, priority pointer = A, all outputs 0.
- IDLE ready logic (combinational):
  - req_ready_a = valid_a & (ptr==A | !valid_b).
  - req_ready_b = valid_b & (ptr==B | !valid_a).
  - At most one ready is high. Both readies are 0 outside IDLE.
- On a handshake:
  - Latch the winner id and its we, raddr1, raddr2, waddr and wdata.
  - Go to READ.
  - Flip the pointer to the loser. The pointer always points away from the requester just granted.
  - The requester may change its inputs on the next cycle.
- READ:
  - Drive rf_raddr1/2 from the latched addresses.
  - Capture rf_rdata1/2 into rsp_rdata1/2 at the end of the cycle.
  - Go to WRITE.
- WRITE:
  - rf_we = latched we.
  - rf_waddr and rf_wdata come from the latches.
  - Go to RESP.
- RESP:
  - Assert rsp_valid of the latched winner for exactly one cycle.
  - Go to IDLE.
  - There is no response backpressure.
- Reads are captured before the write, so a request whose raddr equals its own waddr returns the old value.
- When no operation is active, rf_raddr1/2, rf_waddr and rf_wdata hold their last values. rf_we is 0 in every state except WRITE.
- rsp_rdata1/2 hold their value until the next READ capture.

## Timing
- Handshake at edge N. READ occupies cycle N..N+1, WRITE N+1..N+2, RESP N+2..N+3.
  - rf_we is high for exactly the one cycle after edge N+1, and the register file is updated at edge N+2.
  - rsp_valid is high during the cycle after edge N+2.
- Earliest next handshake is at edge N+4 (IDLE cycle). Throughput is 1 operation per 4 cycles.
- Simultaneous valid_a and valid_b: the pointer holder wins. The loser must hold valid and payload, and is granted on the next IDLE cycle.
  - Under continuous requests from both, grants strictly alternate.
- A request that deasserts valid before being granted is dropped silently. Dropping valid without a handshake is allowed.
- Reset mid-operation (any state):
  - Immediately return to IDLE and set the pointer to A.
  - rf_we = 0, rsp_valid_a/b = 0, rsp_rdata and rf_* address/data = 0.
  - The interrupted write is not performed, and no response is issued for it.
- Address width: all addresses are BITS_ADDR wide with no wrap or range check. Address 2^BITS_ADDR-1 is an ordinary register.

## Test plan
- Reset, then A requests with we=1, waddr=3, wdata=0xDEADBEEF, raddr1=raddr2=0:
  - req_ready_a is high in that cycle.
  - rf_we pulses once with rf_waddr=3 and rf_wdata=0xDEADBEEF.
  - rsp_valid_a pulses exactly 3 cycles after the handshake.
- Next, B requests with we=0, raddr1=3, raddr2=3 -> rsp_rdata1 = rsp_rdata2 = 0xDEADBEEF, rsp_valid_b pulses once, and rf_we stays 0.
- R5 = 0x11, then A requests with raddr1=5, waddr=5, wdata=0x22, we=1 -> rsp_rdata1 = 0x11, and a later read of 5 returns 0x22.
- A and B both hold valid for 8 operations from reset -> grant order is A,B,A,B,A,B,A,B, consecutive handshakes are 4 cycles apart, and no ready is high outside IDLE.
- Reset asserted during WRITE of a we=1 request to R6 (R6 = 0x5 beforehand) -> rf_we drops immediately, no rsp_valid, a later read of R6 returns 0x5, and the first grant after reset goes to A when both request.
- Only B requests while ptr=A -> B is granted in the same cycle, and the pointer then points to A.

Source files
------------

// File: rtl/regfile_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// regfile_port_arbiter_if
//
// Purpose: bundles every signal between the register-file port arbiter, its
// two requesters (A and B) and the 8-entry register file it controls.
//
// Handshake: a request transfers on a rising clk edge where req_valid_x and
// req_ready_x are both high. A requester that is not granted must hold
// req_valid_x and its payload stable until it is granted, or may drop
// req_valid_x to withdraw the request. Ready never depends on anything but the
// arbiter state, its pointer and the two valids. Responses (rsp_valid_x) are a
// one-cycle strobe with no backpressure.
//
// Signal groups:
//   req_*_a / req_*_b : request valid/ready, we, raddr1, raddr2, waddr, wdata
//   rsp_*             : per-requester response strobe, shared read results
//   rf_*              : register file read/write port (read is combinational)
//
// Modports:
//   master : arbiter side
//   slave  : requesters + register file side
// -----------------------------------------------------------------------------
interface regfile_port_arbiter_if #(
   parameter int BITS_DATA = 32,
   parameter int BITS_ADDR = 3
);

   // requester A
   logic                 req_valid_a;
   logic                 req_ready_a;
   logic                 req_we_a;
   logic [BITS_ADDR-1:0] req_raddr1_a;
   logic [BITS_ADDR-1:0] req_raddr2_a;
   logic [BITS_ADDR-1:0] req_waddr_a;
   logic [BITS_DATA-1:0] req_wdata_a;

   // requester B
   logic                 req_valid_b;
   logic                 req_ready_b;
   logic                 req_we_b;
   logic [BITS_ADDR-1:0] req_raddr1_b;
   logic [BITS_ADDR-1:0] req_raddr2_b;
   logic [BITS_ADDR-1:0] req_waddr_b;
   logic [BITS_DATA-1:0] req_wdata_b;

   // responses
   logic                 rsp_valid_a;
   logic                 rsp_valid_b;
   logic [BITS_DATA-1:0] rsp_rdata1;
   logic [BITS_DATA-1:0] rsp_rdata2;

   // register file port
   logic [BITS_ADDR-1:0] rf_raddr1;
   logic [BITS_ADDR-1:0] rf_raddr2;
   logic [BITS_DATA-1:0] rf_rdata1;
   logic [BITS_DATA-1:0] rf_rdata2;
   logic                 rf_we;
   logic [BITS_ADDR-1:0] rf_waddr;
   logic [BITS_DATA-1:0] rf_wdata;

   modport master (
      input  req_valid_a, req_we_a, req_raddr1_a, req_raddr2_a, req_waddr_a, req_wdata_a,
      input  req_valid_b, req_we_b, req_raddr1_b, req_raddr2_b, req_waddr_b, req_wdata_b,
      output req_ready_a, req_ready_b,
      output rsp_valid_a, rsp_valid_b, rsp_rdata1, rsp_rdata2,
      output rf_raddr1, rf_raddr2, rf_we, rf_waddr, rf_wdata,
      input  rf_rdata1, rf_rdata2
   );

   modport slave (
      output req_valid_a, req_we_a, req_raddr1_a, req_raddr2_a, req_waddr_a, req_wdata_a,
      output req_valid_b, req_we_b, req_raddr1_b, req_raddr2_b, req_waddr_b, req_wdata_b,
      input  req_ready_a, req_ready_b,
      input  rsp_valid_a, rsp_valid_b, rsp_rdata1, rsp_rdata2,
      input  rf_raddr1, rf_raddr2, rf_we, rf_waddr, rf_wdata,
      output rf_rdata1, rf_rdata2
   );

endinterface

// File: rtl/regfile_port_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_port_arbiter
//
// Purpose: shares one register file between requesters A and B. Each request
// is a read-read-optional-write operation. The arbiter grants round-robin,
// latches the winning request and sequences the register file through
// READ -> WRITE -> RESP, one operation every four cycles.
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   asynchronous active-high reset
//   bus          if   regfile_port_arbiter_if.master (requests, responses,
//                     register file port)
//   dbg_state_o  out  current FSM state (0 IDLE, 1 READ, 2 WRITE, 3 RESP)
//   dbg_ptr_o    out  priority pointer (0 = A has priority, 1 = B)
// -----------------------------------------------------------------------------
module regfile_port_arbiter #(
   parameter int BITS_DATA = 32,
   parameter int BITS_ADDR = 3
) (
   input  logic                          clk,
   input  logic                          reset,
   regfile_port_arbiter_if.master        bus,
   output logic [1:0]                    dbg_state_o,
   output logic                          dbg_ptr_o
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_WRITE = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   localparam logic SIDE_A = 1'b0;
   localparam logic SIDE_B = 1'b1;

   state_t               state_q,   state_d;
   logic                 ptr_q,     ptr_d;
   logic                 win_q,     win_d;
   logic                 we_q,      we_d;
   logic [BITS_ADDR-1:0] raddr1_q,  raddr1_d;
   logic [BITS_ADDR-1:0] raddr2_q,  raddr2_d;
   logic [BITS_ADDR-1:0] waddr_q,   waddr_d;
   logic [BITS_DATA-1:0] wdata_q,   wdata_d;
   logic [BITS_DATA-1:0] rdata1_q,  rdata1_d;
   logic [BITS_DATA-1:0] rdata2_q,  rdata2_d;

   logic ready_a;
   logic ready_b;
   logic rf_we;
   logic rsp_valid_a;
   logic rsp_valid_b;

   // ---------------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         ptr_q    <= SIDE_A;
         win_q    <= SIDE_A;
         we_q     <= 1'b0;
         raddr1_q <= '0;
         raddr2_q <= '0;
         waddr_q  <= '0;
         wdata_q  <= '0;
         rdata1_q <= '0;
         rdata2_q <= '0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         win_q    <= win_d;
         we_q     <= we_d;
         raddr1_q <= raddr1_d;
         raddr2_q <= raddr2_d;
         waddr_q  <= waddr_d;
         wdata_q  <= wdata_d;
         rdata1_q <= rdata1_d;
         rdata2_q <= rdata2_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state and output logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      win_d       = win_q;
      we_d        = we_q;
      raddr1_d    = raddr1_q;
      raddr2_d    = raddr2_q;
      waddr_d     = waddr_q;
      wdata_d     = wdata_q;
      rdata1_d    = rdata1_q;
      rdata2_d    = rdata2_q;
      ready_a     = 1'b0;
      ready_b     = 1'b0;
      rf_we       = 1'b0;
      rsp_valid_a = 1'b0;
      rsp_valid_b = 1'b0;

      case (state_q)
         S_IDLE: begin
            // A requester wins if it holds priority or the other side is idle;
            // the two terms are mutually exclusive so at most one ready rises.
            ready_a = bus.req_valid_a & ((ptr_q == SIDE_A) | ~bus.req_valid_b);
            ready_b = bus.req_valid_b & ((ptr_q == SIDE_B) | ~bus.req_valid_a);
            if (ready_a) begin
               win_d    = SIDE_A;
               ptr_d    = SIDE_B;
               we_d     = bus.req_we_a;
               raddr1_d = bus.req_raddr1_a;
               raddr2_d = bus.req_raddr2_a;
               waddr_d  = bus.req_waddr_a;
               wdata_d  = bus.req_wdata_a;
               state_d  = S_READ;
            end else if (ready_b) begin
               win_d    = SIDE_B;
               ptr_d    = SIDE_A;
               we_d     = bus.req_we_b;
               raddr1_d = bus.req_raddr1_b;
               raddr2_d = bus.req_raddr2_b;
               waddr_d  = bus.req_waddr_b;
               wdata_d  = bus.req_wdata_b;
               state_d  = S_READ;
            end
         end
         S_READ: begin
            // Reads are captured before the WRITE phase, so a request that
            // reads its own destination sees the old value.
            rdata1_d = bus.rf_rdata1;
            rdata2_d = bus.rf_rdata2;
            state_d  = S_WRITE;
         end
         S_WRITE: begin
            rf_we   = we_q;
            state_d = S_RESP;
         end
         S_RESP: begin
            rsp_valid_a = (win_q == SIDE_A);
            rsp_valid_b = (win_q == SIDE_B);
            state_d     = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Outputs. Register file address/data come straight from the request
   // latches, so they hold their last values between operations.
   // ---------------------------------------------------------------------------
   assign bus.req_ready_a = ready_a;
   assign bus.req_ready_b = ready_b;
   assign bus.rsp_valid_a = rsp_valid_a;
   assign bus.rsp_valid_b = rsp_valid_b;
   assign bus.rsp_rdata1  = rdata1_q;
   assign bus.rsp_rdata2  = rdata2_q;
   assign bus.rf_raddr1   = raddr1_q;
   assign bus.rf_raddr2   = raddr2_q;
   assign bus.rf_we       = rf_we;
   assign bus.rf_waddr    = waddr_q;
   assign bus.rf_wdata    = wdata_q;

   assign dbg_state_o = state_q;
   assign dbg_ptr_o   = ptr_q;

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_port_arbiter
//
// Bench for regfile_port_arbiter. It plays both requesters and the register
// file. A reference copy of the register contents (ref_mem) is updated when a
// request is issued; the expected read results are pushed to exp_q at that
// moment and popped when the DUT strobes a response.
// -----------------------------------------------------------------------------
module tb_regfile_port_arbiter;

   localparam int BD = 32;
   localparam int BA = 3;

   // ---------------------------------------------------------------------------
   // Clock / reset
   // ---------------------------------------------------------------------------
   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   regfile_port_arbiter_if #(.BITS_DATA(BD), .BITS_ADDR(BA)) bus();

   logic [1:0] dbg_state;
   logic       dbg_ptr;

   regfile_port_arbiter #(.BITS_DATA(BD), .BITS_ADDR(BA)) dut (
      .clk         (clk),
      .reset       (reset),
      .bus         (bus),
      .dbg_state_o (dbg_state),
      .dbg_ptr_o   (dbg_ptr)
   );

   // ---------------------------------------------------------------------------
   // Register file model (combinational read, write on rising edge) with a
   // preload port used by the bench to seed contents.
   // ---------------------------------------------------------------------------
   logic [BD-1:0] mem [8];
   logic          pl_en   = 1'b0;
   logic [BA-1:0] pl_addr = '0;
   logic [BD-1:0] pl_data = '0;

   always @(posedge clk) begin
      if (bus.rf_we)  mem[bus.rf_waddr] <= bus.rf_wdata;
      else if (pl_en) mem[pl_addr]      <= pl_data;
   end

   assign bus.rf_rdata1 = mem[bus.rf_raddr1];
   assign bus.rf_rdata2 = mem[bus.rf_raddr2];

   // ---------------------------------------------------------------------------
   // Scoreboard state
   // ---------------------------------------------------------------------------
   logic [BD-1:0]       ref_mem [8];
   logic [2*BD:0]       exp_q[$];   // {side, rdata1, rdata2}
   int                  n_tests = 0;
   int                  n_fail  = 0;

   // ---------------------------------------------------------------------------
   // Driver tasks
   // ---------------------------------------------------------------------------
   task automatic clear_req();
      bus.req_valid_a = 1'b0;
      bus.req_valid_b = 1'b0;
   endtask

   task automatic drive_req(input logic side, input logic we, input logic [BA-1:0] r1,
                            input logic [BA-1:0] r2, input logic [BA-1:0] wa,
                            input logic [BD-1:0] wd);
      if (side == 1'b0) begin
         bus.req_valid_a  = 1'b1;
         bus.req_we_a     = we;
         bus.req_raddr1_a = r1;
         bus.req_raddr2_a = r2;
         bus.req_waddr_a  = wa;
         bus.req_wdata_a  = wd;
      end else begin
         bus.req_valid_b  = 1'b1;
         bus.req_we_b     = we;
         bus.req_raddr1_b = r1;
         bus.req_raddr2_b = r2;
         bus.req_waddr_b  = wa;
         bus.req_wdata_b  = wd;
      end
   endtask

   task automatic apply_reset();
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic preload(input logic [BA-1:0] a, input logic [BD-1:0] d);
      @(negedge clk);
      pl_en   = 1'b1;
      pl_addr = a;
      pl_data = d;
      @(posedge clk);
      #1;
      pl_en      = 1'b0;
      ref_mem[a] = d;
   endtask

   // Expected response is fixed the moment the request is accepted: reads see
   // the contents before this operation's own write.
   task automatic push_exp(input logic side, input logic [BA-1:0] r1, input logic [BA-1:0] r2,
                           input logic we, input logic [BA-1:0] wa, input logic [BD-1:0] wd);
      exp_q.push_back({side, ref_mem[r1], ref_mem[r2]});
      if (we) ref_mem[wa] = wd;
   endtask

   // Follows one granted operation from the handshake edge (the caller has
   // just passed it) through the response, checking each cycle.
   task automatic wait_rsp(input logic side, input logic we, input logic [BA-1:0] wa,
                           input logic [BD-1:0] wd);
      logic [2*BD:0] e;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         n_tests++;
         if (bus.req_ready_a !== 1'b0 || bus.req_ready_b !== 1'b0) begin
            n_fail++;
            $display("FAIL op_ready_busy k=%0d got a=%b b=%b exp 0 0", k, bus.req_ready_a, bus.req_ready_b);
         end
         n_tests++;
         if (bus.rf_we !== logic'(k == 2 && we)) begin
            n_fail++;
            $display("FAIL op_rf_we k=%0d got %b exp %b", k, bus.rf_we, logic'(k == 2 && we));
         end
         if (k == 2 && we) begin
            n_tests++;
            if (bus.rf_waddr !== wa || bus.rf_wdata !== wd) begin
               n_fail++;
               $display("FAIL op_rf_write got addr=%0d data=%h exp addr=%0d data=%h",
                        bus.rf_waddr, bus.rf_wdata, wa, wd);
            end
         end
         n_tests++;
         if (bus.rsp_valid_a !== logic'(k == 3 && side == 1'b0) ||
             bus.rsp_valid_b !== logic'(k == 3 && side == 1'b1)) begin
            n_fail++;
            $display("FAIL op_rsp_valid k=%0d got a=%b b=%b exp a=%b b=%b", k,
                     bus.rsp_valid_a, bus.rsp_valid_b,
                     logic'(k == 3 && side == 1'b0), logic'(k == 3 && side == 1'b1));
         end
         if (bus.rsp_valid_a === 1'b1 || bus.rsp_valid_b === 1'b1) begin
            n_tests++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL op_rsp_unexpected got rsp with empty queue exp none");
            end else begin
               e = exp_q.pop_front();
               if (bus.rsp_valid_b !== e[2*BD] || bus.rsp_rdata1 !== e[2*BD-1:BD] ||
                   bus.rsp_rdata2 !== e[BD-1:0]) begin
                  n_fail++;
                  $display("FAIL op_rsp_data got b=%b d1=%h d2=%h exp b=%b d1=%h d2=%h",
                           bus.rsp_valid_b, bus.rsp_rdata1, bus.rsp_rdata2,
                           e[2*BD], e[2*BD-1:BD], e[BD-1:0]);
               end
            end
         end
      end
   endtask

   // Single-requester operation: wait (bounded) for ready, handshake, follow it.
   task automatic issue(input logic side, input logic we, input logic [BA-1:0] r1,
                        input logic [BA-1:0] r2, input logic [BA-1:0] wa,
                        input logic [BD-1:0] wd);
      int   n;
      logic rdy;
      @(negedge clk);
      drive_req(side, we, r1, r2, wa, wd);
      #1;
      n   = 0;
      rdy = side ? bus.req_ready_b : bus.req_ready_a;
      while (rdy !== 1'b1 && n < 16) begin
         @(negedge clk);
         #1;
         n++;
         rdy = side ? bus.req_ready_b : bus.req_ready_a;
      end
      n_tests++;
      if (rdy !== 1'b1) begin
         n_fail++;
         $display("FAIL issue_grant_timeout side=%0d got ready=%b exp 1", side, rdy);
         clear_req();
         return;
      end
      push_exp(side, r1, r2, we, wa, wd);
      @(posedge clk);
      #1;
      clear_req();
      wait_rsp(side, we, wa, wd);
   endtask

   // ---------------------------------------------------------------------------
   // Scenario tasks
   // ---------------------------------------------------------------------------
   task automatic test_reset();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      n_tests++;
      if (bus.req_ready_a !== 1'b0 || bus.req_ready_b !== 1'b0 || bus.rf_we !== 1'b0 ||
          bus.rsp_valid_a !== 1'b0 || bus.rsp_valid_b !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_ctrl got rdy=%b%b we=%b rsp=%b%b exp all 0", bus.req_ready_a,
                  bus.req_ready_b, bus.rf_we, bus.rsp_valid_a, bus.rsp_valid_b);
      end
      n_tests++;
      if (bus.rf_raddr1 !== '0 || bus.rf_raddr2 !== '0 || bus.rf_waddr !== '0 ||
          bus.rf_wdata !== '0 || bus.rsp_rdata1 !== '0 || bus.rsp_rdata2 !== '0) begin
         n_fail++;
         $display("FAIL reset_data got ra1=%0d ra2=%0d wa=%0d wd=%h d1=%h d2=%h exp all 0",
                  bus.rf_raddr1, bus.rf_raddr2, bus.rf_waddr, bus.rf_wdata,
                  bus.rsp_rdata1, bus.rsp_rdata2);
      end
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_write_a();
      issue(1'b0, 1'b1, 3'd0, 3'd0, 3'd3, 32'hDEAD_BEEF);
   endtask

   task automatic test_read_b();
      issue(1'b1, 1'b0, 3'd3, 3'd3, 3'd0, 32'h0);
   endtask

   task automatic test_read_before_write();
      preload(3'd5, 32'h11);
      issue(1'b0, 1'b1, 3'd5, 3'd5, 3'd5, 32'h22);
      issue(1'b1, 1'b0, 3'd5, 3'd2, 3'd0, 32'h0);
   endtask

   task automatic test_back_to_back();
      logic          s;
      logic [2*BD:0] e;
      apply_reset();
      for (int t = 0; t < 32; t++) begin
         @(negedge clk);
         if (t == 0) begin
            drive_req(1'b0, 1'b0, 3'd1, 3'd2, 3'd0, 32'h0);
            drive_req(1'b1, 1'b0, 3'd3, 3'd4, 3'd0, 32'h0);
         end
         #1;
         s = logic'((t / 4) % 2);
         if (t % 4 == 0) push_exp(s, s ? 3'd3 : 3'd1, s ? 3'd4 : 3'd2, 1'b0, 3'd0, 32'h0);
         n_tests++;
         if (bus.req_ready_a !== logic'(t % 4 == 0 && s == 1'b0) ||
             bus.req_ready_b !== logic'(t % 4 == 0 && s == 1'b1)) begin
            n_fail++;
            $display("FAIL b2b_ready t=%0d got a=%b b=%b exp a=%b b=%b", t, bus.req_ready_a,
                     bus.req_ready_b, logic'(t % 4 == 0 && s == 1'b0),
                     logic'(t % 4 == 0 && s == 1'b1));
         end
         n_tests++;
         if (bus.rf_we !== 1'b0 ||
             bus.rsp_valid_a !== logic'(t % 4 == 3 && s == 1'b0) ||
             bus.rsp_valid_b !== logic'(t % 4 == 3 && s == 1'b1)) begin
            n_fail++;
            $display("FAIL b2b_rsp t=%0d got we=%b a=%b b=%b exp we=0 a=%b b=%b", t, bus.rf_we,
                     bus.rsp_valid_a, bus.rsp_valid_b, logic'(t % 4 == 3 && s == 1'b0),
                     logic'(t % 4 == 3 && s == 1'b1));
         end
         if ((bus.rsp_valid_a === 1'b1 || bus.rsp_valid_b === 1'b1) && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_tests++;
            if (bus.rsp_valid_b !== e[2*BD] || bus.rsp_rdata1 !== e[2*BD-1:BD] ||
                bus.rsp_rdata2 !== e[BD-1:0]) begin
               n_fail++;
               $display("FAIL b2b_data t=%0d got b=%b d1=%h d2=%h exp b=%b d1=%h d2=%h", t,
                        bus.rsp_valid_b, bus.rsp_rdata1, bus.rsp_rdata2,
                        e[2*BD], e[2*BD-1:BD], e[BD-1:0]);
            end
         end
         if (t == 31) clear_req();
      end
   endtask

   task automatic test_reset_mid_write();
      apply_reset();
      preload(3'd6, 32'h5);
      @(negedge clk);
      drive_req(1'b0, 1'b1, 3'd6, 3'd0, 3'd6, 32'h77);
      #1;
      n_tests++;
      if (bus.req_ready_a !== 1'b1) begin
         n_fail++;
         $display("FAIL rmid_grant got %b exp 1", bus.req_ready_a);
      end
      @(posedge clk);
      #1;
      clear_req();
      @(negedge clk);             // READ
      @(negedge clk);             // WRITE
      n_tests++;
      if (bus.rf_we !== 1'b1) begin
         n_fail++;
         $display("FAIL rmid_we_before got %b exp 1", bus.rf_we);
      end
      reset = 1'b1;
      #1;
      n_tests++;
      if (bus.rf_we !== 1'b0 || bus.rsp_valid_a !== 1'b0 || bus.rsp_valid_b !== 1'b0 ||
          bus.rf_waddr !== '0 || bus.rf_wdata !== '0 || bus.rsp_rdata1 !== '0) begin
         n_fail++;
         $display("FAIL rmid_reset got we=%b rsp=%b%b wa=%0d wd=%h d1=%h exp all 0", bus.rf_we,
                  bus.rsp_valid_a, bus.rsp_valid_b, bus.rf_waddr, bus.rf_wdata, bus.rsp_rdata1);
      end
      @(negedge clk);
      reset = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         n_tests++;
         if (bus.rsp_valid_a !== 1'b0 || bus.rsp_valid_b !== 1'b0) begin
            n_fail++;
            $display("FAIL rmid_no_rsp k=%0d got a=%b b=%b exp 0 0", k, bus.rsp_valid_a,
                     bus.rsp_valid_b);
         end
      end
      // Both request after reset: A must win, and R6 must still hold 5.
      drive_req(1'b0, 1'b0, 3'd6, 3'd6, 3'd0, 32'h0);
      drive_req(1'b1, 1'b0, 3'd1, 3'd1, 3'd0, 32'h0);
      #1;
      n_tests++;
      if (bus.req_ready_a !== 1'b1 || bus.req_ready_b !== 1'b0) begin
         n_fail++;
         $display("FAIL rmid_first_grant got a=%b b=%b exp a=1 b=0", bus.req_ready_a,
                  bus.req_ready_b);
      end
      push_exp(1'b0, 3'd6, 3'd6, 1'b0, 3'd0, 32'h0);
      @(posedge clk);
      #1;
      clear_req();
      wait_rsp(1'b0, 1'b0, 3'd0, 32'h0);
   endtask

   task automatic test_only_b();
      logic [BD-1:0] wd;
      wd = $urandom();
      apply_reset();
      @(negedge clk);
      drive_req(1'b1, 1'b1, 3'd7, 3'd1, 3'd7, wd);
      #1;
      n_tests++;
      if (bus.req_ready_b !== 1'b1 || bus.req_ready_a !== 1'b0) begin
         n_fail++;
         $display("FAIL onlyb_grant got a=%b b=%b exp a=0 b=1", bus.req_ready_a, bus.req_ready_b);
      end
      push_exp(1'b1, 3'd7, 3'd1, 1'b1, 3'd7, wd);
      @(posedge clk);
      #1;
      clear_req();
      wait_rsp(1'b1, 1'b1, 3'd7, wd);
      // Pointer now points to A: with both requesting, A wins and reads R7.
      @(negedge clk);
      drive_req(1'b0, 1'b0, 3'd7, 3'd7, 3'd0, 32'h0);
      drive_req(1'b1, 1'b0, 3'd2, 3'd2, 3'd0, 32'h0);
      #1;
      n_tests++;
      if (bus.req_ready_a !== 1'b1 || bus.req_ready_b !== 1'b0) begin
         n_fail++;
         $display("FAIL onlyb_ptr got a=%b b=%b exp a=1 b=0", bus.req_ready_a, bus.req_ready_b);
      end
      push_exp(1'b0, 3'd7, 3'd7, 1'b0, 3'd0, 32'h0);
      @(posedge clk);
      #1;
      clear_req();
      wait_rsp(1'b0, 1'b0, 3'd0, 32'h0);
   endtask

   // ---------------------------------------------------------------------------
   // Main sequence and report
   // ---------------------------------------------------------------------------
   initial begin
      bus.req_valid_a  = 1'b0;
      bus.req_we_a     = 1'b0;
      bus.req_raddr1_a = '0;
      bus.req_raddr2_a = '0;
      bus.req_waddr_a  = '0;
      bus.req_wdata_a  = '0;
      bus.req_valid_b  = 1'b0;
      bus.req_we_b     = 1'b0;
      bus.req_raddr1_b = '0;
      bus.req_raddr2_b = '0;
      bus.req_waddr_b  = '0;
      bus.req_wdata_b  = '0;

      test_reset();
      for (int i = 0; i < 8; i++) preload(BA'(i), BD'($urandom_range(32'hFFFF, 1)));

      test_write_a();
      test_read_b();
      test_read_before_write();
      test_back_to_back();
      test_reset_mid_write();
      test_only_b();

      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain got %0d pending exp 0", exp_q.size());
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1, "watchdog expired");
   end

endmodule
